data_bus_arbiter: RTL and testbench

DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

---
 rtl/data_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_data_bus_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - two-master round-robin arbiter in front of the SRAM and mtime slaves
// SRAM answers one cycle after grant, mtime two cycles after grant via the MT_ACCESS state.
module data_bus_arbiter #(
   parameter int PERIPH_SEL_BIT = 11,
   parameter int SRAM_AW        = 9
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               m0_req_i,
   input  logic [31:0]        m0_addr_i,
   input  logic [31:0]        m0_wdata_i,
   input  logic [3:0]         m0_wmask_i,
   input  logic               m0_wen_i,
   output logic               m0_gnt_o,
   output logic               m0_rvalid_o,
   output logic [31:0]        m0_rdata_o,
   input  logic               m1_req_i,
   input  logic [31:0]        m1_addr_i,
   input  logic [31:0]        m1_wdata_i,
   input  logic [3:0]         m1_wmask_i,
   input  logic               m1_wen_i,
   output logic               m1_gnt_o,
   output logic               m1_rvalid_o,
   output logic [31:0]        m1_rdata_o,
   output logic               sram_csb_o,
   output logic               sram_web_o,
   output logic [3:0]         sram_wmask_o,
   output logic [SRAM_AW-1:0] sram_addr_o,
   output logic [31:0]        sram_din_o,
   input  logic [31:0]        sram_dout_i,
   output logic               mtime_csb_o,
   output logic               mtime_wen_o,
   output logic [3:0]         mtime_addr_o,
   output logic [31:0]        mtime_data_o,
   output logic [3:0]         mtime_wmask_o,
   input  logic [31:0]        mtime_data_i
);

   typedef enum logic {IDLE, MT_ACCESS} state_t;

   state_t               state_q;
   logic                 last_q;
   logic                 gnt0, gnt1, gnt_any, sel;
   logic [31:0]          g_addr, g_wdata;
   logic [3:0]           g_wmask;
   logic                 g_wen, g_mtime, sram_go;
   logic                 sram_web_q;
   logic [3:0]           sram_wmask_q;
   logic [SRAM_AW-1:0]   sram_addr_q;
   logic [31:0]          sram_din_q;
   logic                 mt_wen_q, mt_id_q, mt_read_q;
   logic [3:0]           mt_addr_q, mt_wmask_q;
   logic [31:0]          mt_data_q;
   logic                 trk_valid_q, trk_id_q, trk_mtime_q, trk_read_q;
   logic [31:0]          resp_data;
   logic                 unused_addr_bits;

   // last_q = 1 means m1 was granted most recently, so m0 wins the next tie
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (reset_i && state_q == IDLE) begin
         if (m0_req_i && m1_req_i) begin
            gnt0 = last_q;
            gnt1 = !last_q;
         end else begin
            gnt0 = m0_req_i;
            gnt1 = m1_req_i;
         end
      end
   end

   assign gnt_any  = gnt0 | gnt1;
   assign sel      = gnt1;
   assign g_addr   = sel ? m1_addr_i  : m0_addr_i;
   assign g_wdata  = sel ? m1_wdata_i : m0_wdata_i;
   assign g_wmask  = sel ? m1_wmask_i : m0_wmask_i;
   assign g_wen    = sel ? m1_wen_i   : m0_wen_i;
   assign g_mtime  = g_addr[PERIPH_SEL_BIT];
   assign sram_go  = gnt_any && !g_mtime;
   assign unused_addr_bits = ^g_addr;

   assign m0_gnt_o = gnt0;
   assign m1_gnt_o = gnt1;

   assign sram_csb_o   = !sram_go;
   assign sram_web_o   = sram_go ? g_wen   : sram_web_q;
   assign sram_wmask_o = sram_go ? g_wmask : sram_wmask_q;
   assign sram_addr_o  = sram_go ? g_addr[SRAM_AW+1:2] : sram_addr_q;
   assign sram_din_o   = sram_go ? g_wdata : sram_din_q;

   assign mtime_csb_o   = (state_q != MT_ACCESS);
   assign mtime_wen_o   = mt_wen_q;
   assign mtime_addr_o  = mt_addr_q;
   assign mtime_data_o  = mt_data_q;
   assign mtime_wmask_o = mt_wmask_q;

   assign resp_data   = trk_read_q ? (trk_mtime_q ? mtime_data_i : sram_dout_i) : 32'h0;
   assign m0_rvalid_o = trk_valid_q && !trk_id_q;
   assign m1_rvalid_o = trk_valid_q && trk_id_q;
   assign m0_rdata_o  = m0_rvalid_o ? resp_data : 32'h0;
   assign m1_rdata_o  = m1_rvalid_o ? resp_data : 32'h0;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q      <= IDLE;
         last_q       <= 1'b1;
         sram_web_q   <= 1'b0;
         sram_wmask_q <= '0;
         sram_addr_q  <= '0;
         sram_din_q   <= '0;
         mt_wen_q     <= 1'b0;
         mt_id_q      <= 1'b0;
         mt_read_q    <= 1'b0;
         mt_addr_q    <= '0;
         mt_wmask_q   <= '0;
         mt_data_q    <= '0;
         trk_valid_q  <= 1'b0;
         trk_id_q     <= 1'b0;
         trk_mtime_q  <= 1'b0;
         trk_read_q   <= 1'b0;
      end else begin
         trk_valid_q <= 1'b0;
         if (gnt_any) last_q <= sel;
         case (state_q)
            IDLE: begin
               if (gnt_any && g_mtime) begin
                  state_q    <= MT_ACCESS;
                  mt_addr_q  <= g_addr[3:0];
                  mt_data_q  <= g_wdata;
                  mt_wmask_q <= g_wmask;
                  mt_wen_q   <= g_wen;
                  mt_id_q    <= sel;
                  mt_read_q  <= g_wen;
               end else if (gnt_any) begin
                  trk_valid_q  <= 1'b1;
                  trk_id_q     <= sel;
                  trk_mtime_q  <= 1'b0;
                  trk_read_q   <= g_wen;
                  sram_web_q   <= g_wen;
                  sram_wmask_q <= g_wmask;
                  sram_addr_q  <= g_addr[SRAM_AW+1:2];
                  sram_din_q   <= g_wdata;
               end
            end
            MT_ACCESS: begin
               // mtime data is valid the cycle after its chip select, so the response queues now
               state_q     <= IDLE;
               trk_valid_q <= 1'b1;
               trk_id_q    <= mt_id_q;
               trk_mtime_q <= 1'b1;
               trk_read_q  <= mt_read_q;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb/tb_data_bus_arbiter.sv - table-driven bench for data_bus_arbiter with a behavioural SRAM
module tb_data_bus_arbiter;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b0;
   logic        m0_req_i = 1'b0, m1_req_i = 1'b0;
   logic [31:0] m0_addr_i = '0, m1_addr_i = '0;
   logic [31:0] m0_wdata_i = 32'h1111_0000, m1_wdata_i = 32'h0000_0055;
   logic [3:0]  m0_wmask_i = 4'hF, m1_wmask_i = 4'b0001;
   logic        m0_wen_i = 1'b1, m1_wen_i = 1'b1;
   logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        sram_csb_o, sram_web_o;
   logic [3:0]  sram_wmask_o;
   logic [8:0]  sram_addr_o;
   logic [31:0] sram_din_o;
   logic [31:0] sram_dout_i = '0;
   logic        mtime_csb_o, mtime_wen_o;
   logic [3:0]  mtime_addr_o, mtime_wmask_o;
   logic [31:0] mtime_data_o;
   logic [31:0] mtime_data_i = 32'h1234_5678;

   int n_checks = 0;
   int n_fail = 0;

   data_bus_arbiter #(.PERIPH_SEL_BIT(11), .SRAM_AW(9)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
      .m0_wmask_i(m0_wmask_i), .m0_wen_i(m0_wen_i), .m0_gnt_o(m0_gnt_o),
      .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
      .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
      .m1_wmask_i(m1_wmask_i), .m1_wen_i(m1_wen_i), .m1_gnt_o(m1_gnt_o),
      .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
      .sram_csb_o(sram_csb_o), .sram_web_o(sram_web_o), .sram_wmask_o(sram_wmask_o),
      .sram_addr_o(sram_addr_o), .sram_din_o(sram_din_o), .sram_dout_i(sram_dout_i),
      .mtime_csb_o(mtime_csb_o), .mtime_wen_o(mtime_wen_o), .mtime_addr_o(mtime_addr_o),
      .mtime_data_o(mtime_data_o), .mtime_wmask_o(mtime_wmask_o), .mtime_data_i(mtime_data_i)
   );

   always #5 clk_i = ~clk_i;

   // synchronous SRAM: one-cycle read latency, byte-masked writes
   logic [31:0] mem [0:511];
   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 32'h5A5A_0000 | i;
      mem[4] = 32'hDEAD_BEEF;
      mem[5] = 32'hCAFE_F00D;
   end
   always @(posedge clk_i) begin
      if (!sram_csb_o) begin
         if (sram_web_o) sram_dout_i <= mem[sram_addr_o];
         else
            for (int b = 0; b < 4; b++)
               if (sram_wmask_o[b]) mem[sram_addr_o][b*8 +: 8] <= sram_din_o[b*8 +: 8];
      end
   end

   typedef struct {
      logic        m0_req; logic [31:0] m0_addr; logic m0_wen;
      logic        m1_req; logic [31:0] m1_addr; logic m1_wen;
      logic        gnt0, gnt1, scsb, mcsb;
      logic [8:0]  saddr; logic [3:0] maddr;
      logic        rv0; logic [31:0] rd0;
      logic        rv1; logic [31:0] rd1;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (step %0d): got %h, expected %h", name, step, act, exp);
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //                m0req addr        wen m1req addr          wen g0 g1 sc mc saddr maddr rv0 rd0           rv1 rd1
      vecs.push_back('{0, 32'h0,      1, 0, 32'h0,        1, 0, 0, 1, 1, 9'd0, 4'h0, 0, 32'h0,        0, 32'h0});
      vecs.push_back('{1, 32'h10,     1, 1, 32'h14,       1, 1, 0, 0, 1, 9'd4, 4'h0, 0, 32'h0,        0, 32'h0});
      vecs.push_back('{1, 32'h10,     1, 1, 32'h14,       1, 0, 1, 0, 1, 9'd5, 4'h0, 1, 32'hDEADBEEF, 0, 32'h0});
      vecs.push_back('{1, 32'h10,     1, 1, 32'h14,       1, 1, 0, 0, 1, 9'd4, 4'h0, 0, 32'h0,        1, 32'hCAFEF00D});
      vecs.push_back('{1, 32'h10,     1, 1, 32'h14,       1, 0, 1, 0, 1, 9'd5, 4'h0, 1, 32'hDEADBEEF, 0, 32'h0});
      vecs.push_back('{0, 32'h0,      1, 0, 32'h0,        1, 0, 0, 1, 1, 9'd5, 4'h0, 0, 32'h0,        1, 32'hCAFEF00D});
      vecs.push_back('{0, 32'h0,      1, 1, 32'h804,      0, 0, 1, 1, 1, 9'd5, 4'h0, 0, 32'h0,        0, 32'h0});
      vecs.push_back('{1, 32'h10,     1, 0, 32'h0,        1, 0, 0, 1, 0, 9'd5, 4'h4, 0, 32'h0,        0, 32'h0});
      vecs.push_back('{1, 32'h10,     1, 0, 32'h0,        1, 1, 0, 0, 1, 9'd4, 4'h4, 0, 32'h0,        1, 32'h0});
      vecs.push_back('{0, 32'h0,      1, 0, 32'h0,        1, 0, 0, 1, 1, 9'd4, 4'h4, 1, 32'hDEADBEEF, 0, 32'h0});
      vecs.push_back('{1, 32'h800,    1, 0, 32'h0,        1, 1, 0, 1, 1, 9'd4, 4'h4, 0, 32'h0,        0, 32'h0});
      vecs.push_back('{0, 32'h0,      1, 1, 32'h14,       1, 0, 0, 1, 0, 9'd4, 4'h0, 0, 32'h0,        0, 32'h0});
      vecs.push_back('{0, 32'h0,      1, 1, 32'h14,       1, 0, 1, 0, 1, 9'd5, 4'h0, 1, 32'h12345678, 0, 32'h0});
      vecs.push_back('{0, 32'h0,      1, 0, 32'h0,        1, 0, 0, 1, 1, 9'd5, 4'h0, 0, 32'h0,        1, 32'hCAFEF00D});
      vecs.push_back('{0, 32'h0,      1, 1, 32'hABCDE80C, 1, 0, 1, 1, 1, 9'd5, 4'h0, 0, 32'h0,        0, 32'h0});
      vecs.push_back('{0, 32'h0,      1, 0, 32'h0,        1, 0, 0, 1, 0, 9'd5, 4'hC, 0, 32'h0,        0, 32'h0});
      vecs.push_back('{0, 32'h0,      1, 0, 32'h0,        1, 0, 0, 1, 1, 9'd5, 4'hC, 0, 32'h0,        1, 32'h12345678});
      vecs.push_back('{1, 32'h20,     0, 0, 32'h0,        1, 1, 0, 0, 1, 9'd8, 4'hC, 0, 32'h0,        0, 32'h0});
      vecs.push_back('{0, 32'h0,      1, 0, 32'h0,        1, 0, 0, 1, 1, 9'd8, 4'hC, 1, 32'h0,        0, 32'h0});
      vecs.push_back('{1, 32'h20,     1, 0, 32'h0,        1, 1, 0, 0, 1, 9'd8, 4'hC, 0, 32'h0,        0, 32'h0});
      vecs.push_back('{0, 32'h0,      1, 0, 32'h0,        1, 0, 0, 1, 1, 9'd8, 4'hC, 1, 32'h11110000, 0, 32'h0});

      // reset held with both masters requesting: nothing may be granted
      m0_req_i = 1'b1; m1_req_i = 1'b1;
      repeat (2) @(negedge clk_i);
      check("reset_gnt0", -1, m0_gnt_o, 1'b0);
      check("reset_gnt1", -1, m1_gnt_o, 1'b0);
      check("reset_sram_csb", -1, sram_csb_o, 1'b1);
      check("reset_mtime_csb", -1, mtime_csb_o, 1'b1);
      check("reset_rvalid", -1, {m0_rvalid_o, m1_rvalid_o}, 2'b00);
      check("reset_rdata0", -1, m0_rdata_o, 32'h0);
      m0_req_i = 1'b0; m1_req_i = 1'b0;
      #2 reset_i = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk_i); #1;
         m0_req_i = vecs[i].m0_req; m0_addr_i = vecs[i].m0_addr; m0_wen_i = vecs[i].m0_wen;
         m1_req_i = vecs[i].m1_req; m1_addr_i = vecs[i].m1_addr; m1_wen_i = vecs[i].m1_wen;
         @(negedge clk_i);
         check("m0_gnt", i, m0_gnt_o, vecs[i].gnt0);
         check("m1_gnt", i, m1_gnt_o, vecs[i].gnt1);
         check("sram_csb", i, sram_csb_o, vecs[i].scsb);
         check("mtime_csb", i, mtime_csb_o, vecs[i].mcsb);
         check("sram_addr", i, sram_addr_o, vecs[i].saddr);
         check("mtime_addr", i, mtime_addr_o, vecs[i].maddr);
         check("m0_rvalid", i, m0_rvalid_o, vecs[i].rv0);
         check("m1_rvalid", i, m1_rvalid_o, vecs[i].rv1);
         if (vecs[i].rv0) check("m0_rdata", i, m0_rdata_o, vecs[i].rd0);
         if (vecs[i].rv1) check("m1_rdata", i, m1_rdata_o, vecs[i].rd1);
      end

      // slave outputs hold the attributes of their last access
      check("mtime_data_hold", 100, mtime_data_o, 32'h0000_0055);
      check("mtime_wmask_hold", 100, mtime_wmask_o, 4'b0001);
      check("mtime_wen_hold", 100, mtime_wen_o, 1'b1);
      check("sram_din_hold", 100, sram_din_o, 32'h1111_0000);
      check("sram_wmask_hold", 100, sram_wmask_o, 4'hF);
      check("sram_web_hold", 100, sram_web_o, 1'b1);

      // reset pulse in the middle of an mtime access aborts it
      @(posedge clk_i); #1;
      m0_req_i = 1'b1; m0_addr_i = 32'h800; m0_wen_i = 1'b1;
      @(negedge clk_i);
      check("abort_gnt0", 200, m0_gnt_o, 1'b1);
      @(posedge clk_i); #1;
      m0_req_i = 1'b0;
      @(negedge clk_i);
      check("abort_mt_active", 201, mtime_csb_o, 1'b0);
      #1 reset_i = 1'b0;
      m0_req_i = 1'b1; m1_req_i = 1'b1; m0_addr_i = 32'h10; m1_addr_i = 32'h14; m1_wen_i = 1'b1;
      #1;
      check("abort_mtime_csb", 202, mtime_csb_o, 1'b1);
      check("abort_sram_csb", 202, sram_csb_o, 1'b1);
      check("abort_gnt", 202, {m0_gnt_o, m1_gnt_o}, 2'b00);
      m0_req_i = 1'b0; m1_req_i = 1'b0;
      @(negedge clk_i); #2 reset_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         check("abort_no_rvalid", 203 + c, {m0_rvalid_o, m1_rvalid_o}, 2'b00);
      end
      @(posedge clk_i); #1;
      m0_req_i = 1'b1; m1_req_i = 1'b1;
      @(negedge clk_i);
      check("post_reset_gnt0", 210, m0_gnt_o, 1'b1);
      check("post_reset_gnt1", 210, m1_gnt_o, 1'b0);
      @(posedge clk_i); #1;
      m0_req_i = 1'b0; m1_req_i = 1'b0;
      @(negedge clk_i);
      check("post_reset_rvalid0", 211, m0_rvalid_o, 1'b1);
      check("post_reset_rdata0", 211, m0_rdata_o, 32'hDEAD_BEEF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
